// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter.
// Frames are 1 start bit, DATA_BITS data bits (LSB first), optional parity, 1 or 2 stop bits.
// Parity mode and stop-bit count are latched when a word is popped, so they apply per frame.
// Queued words go out back-to-back: the next word is popped on the last clk of the last stop bit.
// Tx_s is registered, so it trails the FSM state by one clk and is glitch-free on the pin.
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [DATA_BITS-1:0]          in_data,
  output logic                          in_ready,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  output logic                          Tx_s,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic                 full, empty, push, pop;

  // Transmitter state
  state_t               state_q, state_d;
  logic [CW-1:0]        clk_cnt;
  logic [IW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_en, par_bit, two_stop_q;
  logic                 tx_q, tx_d;
  logic                 bit_last;
  logic [DATA_BITS-1:0] head;

  assign full       = (count == (AW+1)'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign in_ready   = !full;
  assign push       = in_valid && !full;
  assign fifo_count = count;
  assign busy       = (state_q != IDLE) || !empty;
  assign Tx_s       = tx_q;
  assign bit_last   = (clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign head       = mem[rd_ptr];

  // FIFO data write
  // NOTE: the storage array has no reset; only pointers and count need a known value, and
  // leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // FIFO pointers, occupancy and sticky overflow flag
  // NOTE: sequential state always uses non-blocking assignments so every register samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (in_valid && full) overflow <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state, pop strobe and next serial bit
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_last) state_d = DATA;
      end
      DATA: begin
        tx_d = shift[0];
        if (bit_last && bit_idx == IW'(DATA_BITS - 1))
          state_d = par_en ? PARITY : STOP;
      end
      PARITY: begin
        tx_d = par_bit;
        if (bit_last) state_d = STOP;
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_last && stop_idx == two_stop_q) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit timer, shift register, bit/stop indices, per-frame config and the serial output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_cnt    <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shift      <= '0;
      par_en     <= 1'b0;
      par_bit    <= 1'b0;
      two_stop_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_q <= tx_d;

      if (state_q == IDLE || bit_last) clk_cnt <= '0;
      else                             clk_cnt <= clk_cnt + 1'b1;

      if (state_q != DATA)  bit_idx <= '0;
      else if (bit_last)    bit_idx <= bit_idx + 1'b1;

      if (state_q != STOP)  stop_idx <= 1'b0;
      else if (bit_last)    stop_idx <= 1'b1;

      if (pop) begin
        shift      <= head;
        par_en     <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
        par_bit    <= (parity_mode == 2'b10) ? ~^head : ^head;
        two_stop_q <= two_stop;
      end else if (state_q == DATA && bit_last) begin
        shift <= shift >> 1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo (DATA_BITS=8, FIFO_DEPTH=4, CLKS_PER_BIT=4).
// Frames are given as hand-written bit sequences, written left to right in line order.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic [1:0] parity_mode = 2'b00;
  logic       two_stop = 1'b0;
  logic       Tx_s;
  logic       busy;
  logic [2:0] fifo_count;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(
    .DATA_BITS   (8),
    .FIFO_DEPTH  (4),
    .CLKS_PER_BIT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .parity_mode(parity_mode),
    .two_stop   (two_stop),
    .Tx_s       (Tx_s),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Single-word push: word is sampled at the second rising edge; returns 1ns after it.
  task automatic push_word(input logic [7:0] d);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Observe one serial frame at falling edges. seq[n-1] is the first (start) bit.
  // wait_start=1 waits (bounded) for the start bit; 0 demands it at the very next falling edge.
  task automatic expect_frame(input string name, input logic [11:0] seq, input int n,
                              input bit wait_start);
    int   t;
    logic want, got;
    bit   bad;
    if (wait_start) begin
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (Tx_s !== 1'b0 && t < 400);
      if (Tx_s !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL %s start timeout: Tx_s=%b want 0", name, Tx_s);
        return;
      end
    end else begin
      @(negedge clk);
    end
    for (int i = 0; i < n; i++) begin
      want = seq[n-1-i];
      bad  = 1'b0;
      got  = want;
      for (int k = 0; k < 4; k++) begin
        if (i != 0 || k != 0) @(negedge clk);
        if (Tx_s !== want) begin
          bad = 1'b1;
          got = Tx_s;
        end
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL %s bit %0d: Tx_s=%b want %b", name, i, got, want);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (Tx_s !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1 || fifo_count !== 3'd0 ||
        overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset: Tx_s=%b busy=%b in_ready=%b count=%0d ovf=%b want 1 0 1 0 0",
               Tx_s, busy, in_ready, fifo_count, overflow);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // 0xA5, even parity, one stop: latency then 11 bits (44 clks), then busy low.
  task automatic test_even_parity();
    parity_mode = 2'b01;
    two_stop    = 1'b0;
    push_word(8'hA5);
    @(negedge clk);
    checks++;
    if (Tx_s !== 1'b1 || fifo_count !== 3'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL t1_after_push: Tx_s=%b count=%0d busy=%b want 1 1 1", Tx_s, fifo_count, busy);
    end
    @(negedge clk);
    checks++;
    if (Tx_s !== 1'b1 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL t1_after_pop: Tx_s=%b count=%0d want 1 0", Tx_s, fifo_count);
    end
    expect_frame("t1_a5_even", 12'b0101_0010_101, 11, 1'b0);
    checks++;
    if (busy !== 1'b0 || Tx_s !== 1'b1) begin
      errors++;
      $display("FAIL t1_end: busy=%b Tx_s=%b want 0 1", busy, Tx_s);
    end
  endtask

  // 0xA5 odd parity + two stops (48 clks), then no parity (40 clks).
  task automatic test_odd_and_none();
    parity_mode = 2'b10;
    two_stop    = 1'b1;
    push_word(8'hA5);
    expect_frame("t2_a5_odd_2stop", 12'b0101_0010_1111, 12, 1'b1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL t2_odd_end: busy=%b want 0", busy);
    end
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    push_word(8'hA5);
    expect_frame("t2_a5_none", 12'b01_0100_1011, 10, 1'b1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL t2_none_end: busy=%b want 0", busy);
    end
  endtask

  // Three words queued behind a frame in flight: count 3,2,1,0 at pops, zero-gap frames.
  task automatic test_back_to_back();
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    fork
      begin
        push_word(8'hFF);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 8'h01;
        @(posedge clk); #1;
        in_data = 8'h02;
        @(posedge clk); #1;
        in_data = 8'h03;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (fifo_count !== 3'd3) begin
          errors++;
          $display("FAIL t3_count_queued: count=%0d want 3", fifo_count);
        end
      end
      begin
        expect_frame("t3_ff", 12'b01_1111_1111, 10, 1'b1);
        checks++;
        if (fifo_count !== 3'd2) begin
          errors++;
          $display("FAIL t3_count_pop1: count=%0d want 2", fifo_count);
        end
        expect_frame("t3_01", 12'b01_0000_0001, 10, 1'b0);
        checks++;
        if (fifo_count !== 3'd1) begin
          errors++;
          $display("FAIL t3_count_pop2: count=%0d want 1", fifo_count);
        end
        expect_frame("t3_02", 12'b00_1000_0001, 10, 1'b0);
        checks++;
        if (fifo_count !== 3'd0) begin
          errors++;
          $display("FAIL t3_count_pop3: count=%0d want 0", fifo_count);
        end
        expect_frame("t3_03", 12'b01_1000_0001, 10, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL t3_end: busy=%b want 0", busy);
        end
      end
    join
  endtask

  // in_valid held 6 edges from IDLE: 5 accepted, 6th rejected, overflow sticks, 0x16 never sent.
  task automatic test_overflow();
    int bad_cycles;
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    fork
      begin
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 8'h11;
        for (int j = 1; j <= 4; j++) begin
          @(posedge clk); #1;
          in_data = 8'(8'h11 + j);
        end
        @(posedge clk); #1;
        in_data = 8'h16;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || fifo_count !== 3'd4 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL t4_full: in_ready=%b count=%0d ovf=%b want 0 4 0",
                   in_ready, fifo_count, overflow);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (overflow !== 1'b1 || fifo_count !== 3'd4) begin
          errors++;
          $display("FAIL t4_reject: ovf=%b count=%0d want 1 4", overflow, fifo_count);
        end
      end
      begin
        expect_frame("t4_11", 12'b01_0001_0001, 10, 1'b1);
        expect_frame("t4_12", 12'b00_1001_0001, 10, 1'b0);
        expect_frame("t4_13", 12'b01_1001_0001, 10, 1'b0);
        expect_frame("t4_14", 12'b00_0101_0001, 10, 1'b0);
        expect_frame("t4_15", 12'b01_0101_0001, 10, 1'b0);
      end
    join
    bad_cycles = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (Tx_s !== 1'b1 || busy !== 1'b0) bad_cycles++;
    end
    checks++;
    if (bad_cycles != 0) begin
      errors++;
      $display("FAIL t4_idle_after: %0d cycles not idle, want 0", bad_cycles);
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL t4_sticky: ovf=%b want 1", overflow);
    end
  endtask

  // Reset during DATA of the 2nd of 3 frames: line high at once, FIFO emptied, nothing after.
  task automatic test_reset_mid_frame();
    int bad_cycles;
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    fork
      begin
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 8'h33;
        @(posedge clk); #1;
        in_data = 8'h44;
        @(posedge clk); #1;
        in_data = 8'h55;
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
      begin
        expect_frame("t5_33", 12'b01_1001_1001, 10, 1'b1);
        repeat (5) @(negedge clk);
        checks++;
        if (Tx_s !== 1'b0 || fifo_count !== 3'd1) begin
          errors++;
          $display("FAIL t5_pre_reset: Tx_s=%b count=%0d want 0 1", Tx_s, fifo_count);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (Tx_s !== 1'b1 || fifo_count !== 3'd0 || busy !== 1'b0 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL t5_async_reset: Tx_s=%b count=%0d busy=%b ovf=%b want 1 0 0 0",
                   Tx_s, fifo_count, busy, overflow);
        end
      end
    join
    @(posedge clk); #1;
    rst = 1'b0;
    bad_cycles = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (Tx_s !== 1'b1 || busy !== 1'b0) bad_cycles++;
    end
    checks++;
    if (bad_cycles != 0) begin
      errors++;
      $display("FAIL t5_after_release: %0d cycles not idle, want 0", bad_cycles);
    end
  endtask

  // parity_mode changed mid-frame: frame 1 keeps even parity, frame 2 uses odd.
  task automatic test_config_latch();
    parity_mode = 2'b01;
    two_stop    = 1'b0;
    fork
      begin
        push_word(8'h0F);
        repeat (12) @(posedge clk);
        #1 parity_mode = 2'b10;
        push_word(8'h0F);
      end
      begin
        expect_frame("t6_even", 12'b0111_1000_001, 11, 1'b1);
        expect_frame("t6_odd", 12'b0111_1000_011, 11, 1'b0);
      end
    join
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL t6_end: busy=%b want 0", busy);
    end
    parity_mode = 2'b00;
  endtask

  initial begin
    test_reset();
    test_even_parity();
    test_odd_and_none();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    test_config_latch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
